// File: rtl/ssram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ssram_arbiter
// Brief    : Round-robin two-master Wishbone arbiter for the ssram slave, with
//            CPU address window, boot-mode lockout and per-strobe ack watchdog.
// Revision : 1.0
// ============================================================================
module ssram_arbiter #(
   parameter logic [29:0] WIN_LIMIT = 30'h00080000,
   parameter int          TIMEOUT   = 64,
   parameter int          CNT_W     = 8
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        boot_mode_i,
   // master 0: ao68000 CPU
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [29:0] m0_adr_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   // master 1: sd DMA
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [29:0] m1_adr_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   // ssram slave
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [18:0] s_adr_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   output logic [1:0]  gnt_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_GNT0 = 3'd1;
   localparam logic [2:0] S_GNT1 = 3'd2;
   localparam logic [2:0] S_ERR  = 3'd3;
   localparam logic [2:0] S_DROP = 3'd4;

   localparam logic [CNT_W-1:0] c_wdog_last = CNT_W'(TIMEOUT - 1);

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic             r_last_gnt;
   logic             w_last_gnt_nxt;
   logic [CNT_W-1:0] r_wdog;
   logic [CNT_W-1:0] w_wdog_nxt;
   logic [CNT_W-1:0] w_wdog_inc;
   logic             w_req0;
   logic             w_req1;
   logic             w_granted;
   logic             w_own_cyc;
   logic             w_own_stb;
   logic             w_stb_live;
   logic             w_unused_adr;

   assign w_req0 = m0_cyc_i & (m0_adr_i < WIN_LIMIT) & ~boot_mode_i;
   assign w_req1 = m1_cyc_i;

   // In GNTx, ERR and DROP the current owner is always r_last_gnt.
   assign w_own_cyc  = r_last_gnt ? m1_cyc_i : m0_cyc_i;
   assign w_own_stb  = r_last_gnt ? m1_stb_i : m0_stb_i;
   assign w_granted  = (r_state == S_GNT0) | (r_state == S_GNT1);
   assign w_stb_live = w_granted & w_own_cyc & w_own_stb;
   assign w_wdog_inc = r_wdog + 1'b1;

   // Only the low 19 word-address bits reach the ssram.
   assign w_unused_adr = ^m1_adr_i[29:19];

   always_comb begin
      w_state_nxt    = r_state;
      w_last_gnt_nxt = r_last_gnt;
      w_wdog_nxt     = '0;
      case (r_state)
         S_IDLE: begin
            if (w_req0 && (!w_req1 || r_last_gnt)) begin
               w_state_nxt    = S_GNT0;
               w_last_gnt_nxt = 1'b0;
            end else if (w_req1) begin
               w_state_nxt    = S_GNT1;
               w_last_gnt_nxt = 1'b1;
            end
         end
         S_GNT0, S_GNT1: begin
            if (!w_own_cyc) begin
               w_state_nxt = S_IDLE;
            end else if (w_stb_live && !s_ack_i) begin
               // An unacked strobe cycle that would bring the count to
               // TIMEOUT-1 ends the transfer; a same-cycle ack takes priority.
               if (w_wdog_inc == c_wdog_last) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_wdog_nxt = w_wdog_inc;
               end
            end
         end
         S_ERR: begin
            w_state_nxt = S_DROP;
         end
         S_DROP: begin
            if (!w_own_cyc) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_state    <= S_IDLE;
         r_last_gnt <= 1'b1;
         r_wdog     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_last_gnt <= w_last_gnt_nxt;
         r_wdog     <= w_wdog_nxt;
      end
   end

   // Slave side follows the owner only while its cycle is open, so the
   // hand-back cycle and every non-granted cycle present an all-zero bus.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_sel_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      case (r_state)
         S_GNT0: begin
            m0_ack_o = s_ack_i;
            if (m0_cyc_i) begin
               s_cyc_o = 1'b1;
               s_stb_o = m0_stb_i;
               s_we_o  = m0_we_i;
               s_adr_o = m0_adr_i[18:0];
               s_sel_o = m0_sel_i;
               s_dat_o = m0_dat_i;
            end
         end
         S_GNT1: begin
            m1_ack_o = s_ack_i;
            if (m1_cyc_i) begin
               s_cyc_o = 1'b1;
               s_stb_o = m1_stb_i;
               s_we_o  = m1_we_i;
               s_adr_o = m1_adr_i[18:0];
               s_sel_o = m1_sel_i;
               s_dat_o = m1_dat_i;
            end
         end
         S_ERR: begin
            m0_err_o = ~r_last_gnt;
            m1_err_o = r_last_gnt;
         end
         default: begin
         end
      endcase
   end

   assign gnt_o = {r_state == S_GNT1, r_state == S_GNT0};

endmodule
`default_nettype wire

// File: tb/tb_ssram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssram_arbiter
// Brief    : Self-checking bench for ssram_arbiter (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_ssram_arbiter;

   localparam int TO = 64;

   logic        clk;
   logic        rst_n;
   logic        boot_mode;
   logic        m0_cyc, m0_stb, m0_we;
   logic [29:0] m0_adr;
   logic [3:0]  m0_sel;
   logic [31:0] m0_dat;
   logic        m0_ack, m0_err;
   logic        m1_cyc, m1_stb, m1_we;
   logic [29:0] m1_adr;
   logic [3:0]  m1_sel;
   logic [31:0] m1_dat;
   logic        m1_ack, m1_err;
   logic        s_cyc, s_stb, s_we;
   logic [18:0] s_adr;
   logic [3:0]  s_sel;
   logic [31:0] s_dat;
   logic        s_ack;
   logic [1:0]  gnt;

   ssram_arbiter #(.WIN_LIMIT(30'h00080000), .TIMEOUT(TO), .CNT_W(8)) dut (
      .CLK_I(clk), .RST_I(rst_n), .boot_mode_i(boot_mode),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
      .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
      .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
      .s_sel_o(s_sel), .s_dat_o(s_dat), .s_ack_i(s_ack), .gnt_o(gnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, want);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      int          m;
      logic [18:0] adr;
      logic        we;
      logic [31:0] dat;
   } exp_t;
   exp_t sbq[$];

   task automatic push(input int m, input logic [18:0] adr, input logic we, input logic [31:0] dat);
      exp_t e;
      e.m = m; e.adr = adr; e.we = we; e.dat = dat;
      sbq.push_back(e);
   endtask

   logic [1:0] prev_gnt;
   initial begin
      exp_t e;
      prev_gnt = 2'b00;
      forever begin
         @(negedge clk);
         if (rst_n && s_cyc && s_stb && s_ack) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected_beat: got adr=%0h gnt=%0h want none", s_adr, gnt);
            end else begin
               e = sbq.pop_front();
               chk("sb_gnt", gnt, (e.m == 0) ? 2'b01 : 2'b10);
               chk("sb_adr", s_adr, e.adr);
               chk("sb_we", s_we, e.we);
               chk("sb_dat", s_dat, e.dat);
               chk("sb_sel", s_sel, 4'hF);
               chk("sb_owner_ack", (e.m == 0) ? m0_ack : m1_ack, 1'b1);
               chk("sb_other_ack", (e.m == 0) ? m1_ack : m0_ack, 1'b0);
            end
         end
         if (gnt != 2'b00 && prev_gnt != 2'b00) chk("gnt_gap", gnt, prev_gnt);
         prev_gnt = gnt;
      end
   end

   // ---------------- slave model ----------------
   logic ack_en;
   logic force_ack;
   int   ack_lat;
   int   lat_cnt;
   initial begin
      s_ack   = 1'b0;
      lat_cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (force_ack) begin
            s_ack = 1'b1;
         end else if (s_ack) begin
            s_ack   = 1'b0;
            lat_cnt = 0;
         end else if (ack_en && s_cyc && s_stb) begin
            if (lat_cnt == ack_lat) begin
               s_ack   = 1'b1;
               lat_cnt = 0;
            end else begin
               lat_cnt++;
            end
         end else begin
            lat_cnt = 0;
         end
      end
   end

   // ---------------- master helpers ----------------
   task automatic drive(input int m, input logic on, input logic [29:0] adr,
                        input logic we, input logic [31:0] dat);
      if (m == 0) begin
         m0_cyc = on; m0_stb = on; m0_we = on & we; m0_adr = adr;
         m0_sel = on ? 4'hF : 4'h0; m0_dat = dat;
      end else begin
         m1_cyc = on; m1_stb = on; m1_we = on & we; m1_adr = adr;
         m1_sel = on ? 4'hF : 4'h0; m1_dat = dat;
      end
   endtask

   // Starts and ends 1 time unit after a rising edge.
   task automatic m_xfer(input int m, input logic [29:0] adr, input logic we,
                         input logic [31:0] dat, input int budget,
                         output logic got_ack, output logic got_err, output int cyc_lat);
      got_ack = 1'b0;
      got_err = 1'b0;
      cyc_lat = -1;
      drive(m, 1'b1, adr, we, dat);
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (cyc_lat < 0 && s_cyc && gnt[m]) cyc_lat = i;
         if ((m == 0) ? m0_ack : m1_ack) begin
            got_ack = 1'b1;
            break;
         end
         if ((m == 0) ? m0_err : m1_err) begin
            got_err = 1'b1;
            break;
         end
      end
      drive(m, 1'b0, 30'h0, 1'b0, 32'h0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          m;
      logic [29:0] adr;
      logic        we;
      logic [31:0] dat;
      logic        boot;
      logic        exp_ack;
      logic [18:0] exp_adr;
   } vec_t;
   vec_t vecs[9];

   logic a0, e0, a1, e1, seen_err, boot_at_ack;
   int   l0, l1, n, exp_last, first;

   initial begin
      vecs[0] = '{0, 30'h00000100, 1'b0, 32'h00000000, 1'b0, 1'b1, 19'h00100};
      vecs[1] = '{0, 30'h0007FFFF, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 19'h7FFFF};
      vecs[2] = '{0, 30'h00080000, 1'b0, 32'h00000000, 1'b0, 1'b0, 19'h00000};
      vecs[3] = '{0, 30'h3FFFFFFF, 1'b1, 32'h00000001, 1'b0, 1'b0, 19'h00000};
      vecs[4] = '{1, 30'h3FFFFFFF, 1'b1, 32'h12345678, 1'b0, 1'b1, 19'h7FFFF};
      vecs[5] = '{0, 30'h00000000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 19'h00000};
      vecs[6] = '{1, 30'h00012345, 1'b0, 32'h0BADF00D, 1'b0, 1'b1, 19'h12345};
      vecs[7] = '{0, 30'h00000100, 1'b0, 32'h00000000, 1'b1, 1'b0, 19'h00000};
      vecs[8] = '{1, 30'h00000002, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 19'h00002};

      ack_en = 1'b1; force_ack = 1'b0; ack_lat = 2;
      boot_mode = 1'b0;
      rst_n = 1'b0;
      drive(0, 1'b1, 30'h00000100, 1'b1, 32'h11112222);
      drive(1, 1'b1, 30'h00000200, 1'b1, 32'h33334444);
      #12;
      chk("rst_s_cyc", s_cyc, 1'b0);
      chk("rst_s_stb", s_stb, 1'b0);
      chk("rst_s_we", s_we, 1'b0);
      chk("rst_s_adr", s_adr, 19'h0);
      chk("rst_s_sel", s_sel, 4'h0);
      chk("rst_s_dat", s_dat, 32'h0);
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 4'h0);
      drive(0, 1'b0, 30'h0, 1'b0, 32'h0);
      drive(1, 1'b0, 30'h0, 1'b0, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_last = 1;
      @(posedge clk); #1;

      // single-master table
      for (int k = 0; k < 9; k++) begin
         boot_mode = vecs[k].boot;
         if (vecs[k].exp_ack) push(vecs[k].m, vecs[k].exp_adr, vecs[k].we, vecs[k].dat);
         m_xfer(vecs[k].m, vecs[k].adr, vecs[k].we, vecs[k].dat, 12, a0, e0, l0);
         chk($sformatf("vec%0d_ack", k), a0, vecs[k].exp_ack);
         chk($sformatf("vec%0d_err", k), e0, 1'b0);
         chk($sformatf("vec%0d_lat", k), l0, vecs[k].exp_ack ? 1 : -1);
         if (vecs[k].exp_ack) exp_last = vecs[k].m;
         @(posedge clk); #1;
      end
      boot_mode = 1'b0;

      // simultaneous requests, three rounds
      for (int r = 0; r < 3; r++) begin
         first = (exp_last == 1) ? 0 : 1;
         if (first == 0) begin
            push(0, 19'(32'h200 + r), r[0], 32'h1000 + r);
            push(1, 19'(32'h300 + r), ~r[0], 32'h2000 + r);
         end else begin
            push(1, 19'(32'h300 + r), ~r[0], 32'h2000 + r);
            push(0, 19'(32'h200 + r), r[0], 32'h1000 + r);
         end
         fork
            m_xfer(0, 30'(32'h200 + r), r[0], 32'h1000 + r, 30, a0, e0, l0);
            m_xfer(1, 30'(32'h300 + r), ~r[0], 32'h2000 + r, 30, a1, e1, l1);
         join
         chk("rr_m0_ack", a0, 1'b1);
         chk("rr_m1_ack", a1, 1'b1);
         chk("rr_winner_lat", (first == 0) ? l0 : l1, 1);
         exp_last = 1 - first;
         @(posedge clk); #1;
      end

      // boot lockout: only m1 while boot_mode, m0 afterwards
      boot_mode = 1'b1;
      push(1, 19'h00500, 1'b1, 32'hCAFEF00D);
      push(0, 19'h00040, 1'b0, 32'h0);
      boot_at_ack = 1'b1;
      fork
         begin
            m_xfer(0, 30'h00000040, 1'b0, 32'h0, 60, a0, e0, l0);
            boot_at_ack = boot_mode;
         end
         begin
            m_xfer(1, 30'h00000500, 1'b1, 32'hCAFEF00D, 20, a1, e1, l1);
            repeat (6) @(posedge clk);
            #1;
            boot_mode = 1'b0;
         end
      join
      chk("boot_m1_ack", a1, 1'b1);
      chk("boot_m0_ack", a0, 1'b1);
      chk("boot_m0_after_release", boot_at_ack, 1'b0);
      @(posedge clk); #1;

      // watchdog: slave never acks
      ack_en = 1'b0;
      drive(1, 1'b1, 30'h00000040, 1'b0, 32'h0);
      n = 0;
      seen_err = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (m1_err) begin
            seen_err = 1'b1;
            break;
         end
         if (s_stb) n++;
      end
      chk("wdog_err_seen", seen_err, 1'b1);
      chk("wdog_stb_cycles", n, TO - 1);
      force_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #3;
         chk("drop_s_cyc", s_cyc, 1'b0);
         chk("drop_ack_blocked", m1_ack, 1'b0);
         chk("drop_err_once", m1_err, 1'b0);
      end
      force_ack = 1'b0;
      drive(1, 1'b0, 30'h0, 1'b0, 32'h0);
      ack_en = 1'b1;
      @(posedge clk); #1;
      chk("drop_to_idle_gnt", gnt, 2'b00);
      push(0, 19'h00077, 1'b1, 32'h77777777);
      m_xfer(0, 30'h00000077, 1'b1, 32'h77777777, 12, a0, e0, l0);
      chk("post_drop_ack", a0, 1'b1);
      chk("post_drop_lat", l0, 1);
      @(posedge clk); #1;

      // ack arriving on the terminal watchdog cycle wins
      ack_lat = TO - 2;
      push(1, 19'h00099, 1'b0, 32'h0);
      m_xfer(1, 30'h00000099, 1'b0, 32'h0, 100, a1, e1, l1);
      chk("tc_ack_wins_ack", a1, 1'b1);
      chk("tc_ack_wins_err", e1, 1'b0);
      ack_lat = 2;
      @(posedge clk); #1;

      // master abandons its cycle mid-strobe
      ack_en = 1'b0;
      drive(1, 1'b1, 30'h00000123, 1'b0, 32'h0);
      repeat (3) begin @(posedge clk); #1; end
      chk("abandon_gnt", gnt, 2'b10);
      drive(1, 1'b0, 30'h0, 1'b0, 32'h0);
      @(posedge clk); #1;
      chk("abandon_idle", gnt, 2'b00);
      chk("abandon_no_err", m1_err, 1'b0);
      ack_en = 1'b1;
      @(posedge clk); #1;

      // asynchronous reset in the middle of an m1 write
      ack_en = 1'b0;
      drive(1, 1'b1, 30'h00000077, 1'b1, 32'h5A5A5A5A);
      @(posedge clk); #1;
      chk("rstmid_pre_cyc", s_cyc, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_s_cyc", s_cyc, 1'b0);
      chk("rstmid_s_stb", s_stb, 1'b0);
      chk("rstmid_s_we", s_we, 1'b0);
      chk("rstmid_gnt", gnt, 2'b00);
      drive(1, 1'b0, 30'h0, 1'b0, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ack_en = 1'b1;
      @(posedge clk); #1;
      push(0, 19'h00011, 1'b0, 32'h0);
      push(1, 19'h00022, 1'b1, 32'h22);
      fork
         m_xfer(0, 30'h00000011, 1'b0, 32'h0, 30, a0, e0, l0);
         m_xfer(1, 30'h00000022, 1'b1, 32'h22, 30, a1, e1, l1);
      join
      chk("post_rst_m0_first_lat", l0, 1);
      chk("post_rst_m1_ack", a1, 1'b1);
      @(posedge clk); #1;

      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running want=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire

// File: doc/ssram_arbiter.md
Name: ssram_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter in front of the ssram controller.
- Master 0 is the ao68000 CPU; master 1 is the sd DMA master.
- Replaces the static boot-phase multiplexing with round-robin arbitration, address-window qualification for the CPU, a boot-mode lockout and a per-transfer ack watchdog.
- Sits between both masters and the ssram slave in full_system.

Parameters:
- WIN_LIMIT, 30'h00080000: exclusive upper bound of the CPU's ssram window, compared against m0_adr_i[31:2]. The lower bound is 0.
- TIMEOUT, 64: cycles a strobe may wait for s_ack_i before an error is returned. Legal range 2..255.
- CNT_W, 8: width of the watchdog counter.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  reset; asynchronous, active-low
- boot_mode_i  in  1  1 = boot loading in progress; only master 1 may be granted
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  CPU Wishbone control
- m0_adr_i  in  30  CPU address [31:2]
- m0_sel_i  in  4  CPU byte selects
- m0_dat_i  in  32  CPU write data
- m0_ack_o, m0_err_o  out  1 each  CPU acknowledge / error
- m1_cyc_i, m1_stb_i, m1_we_i  in  1 each  sd DMA Wishbone control
- m1_adr_i  in  30  sd address [31:2]
- m1_sel_i  in  4  sd byte selects
- m1_dat_i  in  32  sd write data
- m1_ack_o, m1_err_o  out  1 each  sd acknowledge / error
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to ssram
- s_adr_o  out  19  ssram word address = granted master adr[20:2]
- s_sel_o  out  4  to ssram
- s_dat_o  out  32  to ssram
- s_ack_i  in  1  ssram acknowledge
- gnt_o  out  2  one-hot grant; bit0 = CPU, bit1 = sd (debug)

Behaviour:
- Requests:
  - req0 = m0_cyc_i & (m0_adr_i < WIN_LIMIT) & ~boot_mode_i
  - req1 = m1_cyc_i
- States: IDLE, GNT0, GNT1, ERR, DROP. State, last_gnt and wdog are registered.
- Reset (RST_I = 0, asynchronous):
  - state = IDLE, last_gnt = 1 (so the CPU wins the first tie), wdog = 0.
  - Every output is 0 while in reset. s_adr_o, s_sel_o and s_dat_o are also 0.
- Arbitration in IDLE:
  - req0 only: go to GNT0.
  - req1 only: go to GNT1.
  - Both: grant the master that is not last_gnt.
  - last_gnt updates on entry to GNT0 or GNT1.
  - Latency is 1 cycle: s_cyc_o rises the cycle after the request is first seen in IDLE.
- GNTx:
  - s_cyc/stb/we/adr/sel/dat are combinationally driven from master x.
  - mx_ack_o = s_ack_i. The non-granted master's ack and err are 0.
  - The grant is held for the whole CYC, so multi-beat and RMW transfers are atomic.
  - Leave to IDLE when mx_cyc_i = 0. Slave outputs are 0 in that cycle. There is at least one idle cycle between owners.
- Non-granted idle slave outputs: s_* control signals are 0 and the data/address buses hold 0.
- Watchdog:
  - In GNTx, wdog increments each cycle with s_stb_o & ~s_ack_i.
  - It clears on s_ack_i, on stb low, and on state exit.
  - When wdog = TIMEOUT-1 with no ack, go to ERR.
- ERR (1 cycle):
  - s_cyc_o = s_stb_o = 0 and mx_err_o = 1.
  - Then go to DROP.
- DROP:
  - Slave outputs are 0; wait for mx_cyc_i = 0, then go to IDLE.
  - Any s_ack_i arriving here is ignored and is not forwarded.
- boot_mode_i:
  - Rising during GNT0: the current CPU cycle completes normally; no new GNT0 is issued.
  - The CPU stalls with no ack while locked out or out of window; this block never errors an unqualified request.
- A master dropping cyc mid-strobe is legal: the transfer is abandoned and the FSM goes to IDLE.
- Simultaneous s_ack_i and wdog terminal count: the ack wins, no error is raised and wdog clears.

Test Plan:
- Reset, then m0 read at word 0x100, ssram acks 2 cycles after stb → s_cyc_o high 1 cycle after m0_cyc_i; s_adr_o = 19'h100; m0_ack_o pulses once; gnt_o = 01.
- m0 and m1 assert cyc on the same cycle, three times back-to-back → grant order m0, m1, m0. m1_ack_o is never seen during m0 ownership, and there is one idle cycle between grants.
- boot_mode_i = 1 with both requesting → only m1 is granted. m0 sees no ack until boot_mode_i = 0, then m0 is granted.
- m0 address 30'h00080000 with cyc=stb=1 → s_cyc_o stays 0, m0_ack_o = m0_err_o = 0.
- m1 strobe with ssram never acking, TIMEOUT = 64 → m1_err_o pulses on the cycle after 63 unacked cycles. s_cyc_o = 0 through DROP; IDLE is reached after m1_cyc_i drops.
- RST_I pulled low mid-GNT1 write → s_cyc_o, s_stb_o, s_we_o and gnt_o go to 0 immediately without a clock edge. After release, the first request from m0 is granted first.
